x2z_row_feeder: RTL and testbench
=================================

Name: x2z_row_feeder

Overview:
- Transmit-side driver for one X2zPeRow link in the transform array.
- Accepts a serial sample stream over a valid/ready handshake and buffers one N-sample block, using ping-pong banks.
- Replays each block to the PE row as N/2 mirrored (x, z) pairs, first in a sum phase and then in a diff phase.
- Drives the signals of the row's tx modport: x, z, sumDiffSel, load, valid.

Parameters:
- DATA_WIDTH, 8, sample width; equals the PE row x/z width.
- N, 8, block length; even, ≥2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  DATA_WIDTH  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder can accept a sample.
- hold  in  1  stall request from the array; freezes emission.
- row_x  out  DATA_WIDTH  drives x; the low-index sample of the pair.
- row_z  out  DATA_WIDTH  drives z; the mirrored sample.
- row_sum_diff_sel  out  1  drives sumDiffSel; 0 = sum phase, 1 = diff phase.
- row_load  out  1  drives load; high on the first beat of each phase.
- row_valid  out  1  drives valid; the beat is meaningful.
- busy  out  1  any bank full or emission in progress.

Behaviour:
- Storage: two banks of N×DATA_WIDTH each.
  - Write side: wr_bank, wr_cnt (0..N-1), full[1:0].
  - Read side: rd_bank, beat index k (0..N/2-1).
- Write side:
  - in_ready = !full[wr_bank]. Combinational from registers; forced 0 while rst_n=0.
  - A handshake occurs when in_valid && in_ready. It writes bank[wr_bank][wr_cnt] and increments wr_cnt.
  - On the handshake with wr_cnt==N-1: set full[wr_bank], toggle wr_bank, wr_cnt←0.
  - Bubbles on in_valid are legal and change nothing.
- Emit FSM states: IDLE, SUM, DIFF.
  - IDLE: if full[rd_bank], go to SUM with k←0. Otherwise stay.
  - SUM, hold=0: register one beat per cycle.
    - row_x←bank[rd_bank][k], row_z←bank[rd_bank][N-1-k].
    - row_sum_diff_sel←0, row_load←(k==0), row_valid←1.
    - At k==N/2-1: go to DIFF with k←0. Otherwise k++.
  - DIFF, hold=0: same indexing, with row_sum_diff_sel←1 and row_load←(k==0).
    - At k==N/2-1: clear full[rd_bank] and toggle rd_bank.
    - Next state is SUM (k←0) if the other bank is already full, else IDLE. This gives back-to-back blocks with no bubble.
  - hold=1 in SUM or DIFF: state and k frozen; row_valid←0 and row_load←0; row_x, row_z and row_sum_diff_sel keep their values. No beat is dropped or repeated.
  - In IDLE, row_valid←0 and row_load←0.
- Latency: Nth-sample handshake in cycle c, then full set at the edge ending c, FSM leaves IDLE at the edge ending c+1, first row_valid=1 in cycle c+2. Without hold, a block produces N contiguous valid beats.
- Throughput: one sample in and one beat out per cycle sustained. in_ready never drops with continuous input and hold=0.
- Simultaneous events:
  - full set (write) and full clear (read) in the same cycle always target different banks. The writer only writes a non-full bank and the reader only reads a full bank; both updates apply.
  - The bank being freed becomes writable the cycle after the clear.
- Both banks full: in_ready=0 until the DIFF-phase last beat of rd_bank is issued.
- Reset (any time, including mid-fill or mid-emission):
  - The next edge with rst_n=0 clears full, wr_bank, rd_bank, wr_cnt, k and state (IDLE).
  - All row_* outputs go to 0 and busy goes to 0.
  - Partial and pending blocks are discarded. Bank contents need no reset.
- busy = full[0] | full[1] | (state!=IDLE).

Test Plan:
- Single block: N=8, samples 1..8, hold=0 → starting cycle c+2, 8 contiguous beats:
  - Sum phase: (x,z)=(1,8),(2,7),(3,6),(4,5) with sel=0.
  - Diff phase: the same pairs with sel=1.
  - row_load high only on beats 0 and 4. busy falls after the last beat.
- Back-to-back: samples 1..16 continuous, hold=0 → in_ready stays 1 throughout. 16 contiguous valid beats; the second block starts with (9,16) with sel=0 and load=1, with no gap.
- Back-pressure: hold=1 while streaming 1..24 → in_ready drops after the 16th handshake and sample 17 waits. Release hold → block 1 emits, then sample 17 is accepted the cycle after block 1's last DIFF beat. All 24 samples emitted in order.
- Mid-block stall: hold=1 for 3 cycles after the beat (2,7) sum → row_valid=0 for 3 cycles, x/z/sel unchanged. The next beat is (3,6) sel=0 with load=0, and the total is still 8 valid beats.
- Reset mid-operation: assert rst_n=0 after 5 samples of block 2 while block 1 is in its DIFF phase → the following cycle has all row_* at 0, busy=0, and in_ready=1 after release. Feeding 101..108 then yields only beats (101,108)… with no residual data.
- Input bubbles: samples 1..8 with in_valid low on alternate cycles → same 8-beat sequence as the single-block case, starting 2 cycles after the 8th handshake.

Source files
------------

// File: rtl/x2z_row_feeder_if.sv
// x2z_row_feeder_if: stream-in and PE-row-out signals of the row feeder.
//   in_data/in_valid/in_ready : serial sample stream (valid/ready)
//   hold                      : stall request from the array
//   row_x/row_z               : mirrored sample pair driven to the PE row
//   row_sum_diff_sel          : 0 = sum phase, 1 = diff phase
//   row_load                  : first beat of a phase
//   row_valid                 : beat is meaningful
// slave = feeder side, master = source/array side.
interface x2z_row_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  hold;
  logic [DATA_WIDTH-1:0] row_x;
  logic [DATA_WIDTH-1:0] row_z;
  logic                  row_sum_diff_sel;
  logic                  row_load;
  logic                  row_valid;

  modport slave (
    input  in_data, in_valid, hold,
    output in_ready, row_x, row_z, row_sum_diff_sel, row_load, row_valid
  );

  modport master (
    output in_data, in_valid, hold,
    input  in_ready, row_x, row_z, row_sum_diff_sel, row_load, row_valid
  );
endinterface

// File: rtl/x2z_row_feeder.sv
// x2z_row_feeder: transmit-side driver for one X2zPeRow link.
// Buffers N-sample blocks in two ping-pong banks and replays each block as
// N/2 mirrored (x, z) pairs, once in the sum phase and once in the diff phase.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : x2z_row_feeder_if.slave (sample stream in, PE row tx out)
//   busy  : a bank is full or an emission is in progress
module x2z_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  x2z_row_feeder_if.slave  bus,
  output logic             busy
);
  localparam int CW = $clog2(N);
  localparam int KW = (N > 2) ? $clog2(N/2) : 1;
  localparam logic [CW-1:0] CLAST = CW'(N-1);
  localparam logic [KW-1:0] KLAST = KW'(N/2-1);

  typedef enum logic [1:0] {IDLE, SUM, DIFF} state_t;

  logic [DATA_WIDTH-1:0] mem [2][N];
  logic                  wr_bank, rd_bank;
  logic [CW-1:0]         wr_cnt;
  logic [1:0]            full;
  state_t                state_q, state_d, eff;
  logic [KW-1:0]         k_q, k_d, keff, beat_k;
  logic                  wr_fire, wr_done, beat, beat_diff, rd_clr;
  logic [CW-1:0]         xidx, zidx;

  assign bus.in_ready = rst_n & ~full[wr_bank];
  assign wr_fire      = bus.in_valid & bus.in_ready;
  assign wr_done      = wr_fire & (wr_cnt == CLAST);
  assign busy         = (|full) | (state_q != IDLE);

  // IDLE with a full read bank behaves as SUM at k=0 in the same cycle, so
  // the first beat is registered on the edge that leaves IDLE.
  always_comb begin
    eff       = state_q;
    keff      = k_q;
    beat      = 1'b0;
    beat_diff = 1'b0;
    rd_clr    = 1'b0;
    if (state_q == IDLE && full[rd_bank]) begin
      eff  = SUM;
      keff = '0;
    end
    state_d = eff;
    k_d     = keff;
    beat_k  = keff;
    if (!bus.hold && eff != IDLE) begin
      beat      = 1'b1;
      beat_diff = (eff == DIFF);
      if (keff != KLAST) begin
        k_d = keff + 1'b1;
      end else begin
        k_d = '0;
        if (eff == SUM) begin
          state_d = DIFF;
        end else begin
          rd_clr  = 1'b1;
          // other bank already full: chain straight into its sum phase
          state_d = full[~rd_bank] ? SUM : IDLE;
        end
      end
    end
  end

  assign xidx = CW'(beat_k);
  assign zidx = CLAST - CW'(beat_k);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      k_q                  <= '0;
      wr_bank              <= 1'b0;
      rd_bank              <= 1'b0;
      wr_cnt               <= '0;
      full                 <= 2'b00;
      bus.row_x            <= '0;
      bus.row_z            <= '0;
      bus.row_sum_diff_sel <= 1'b0;
      bus.row_load         <= 1'b0;
      bus.row_valid        <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (wr_fire) begin
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      // set and clear never hit the same bank
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_clr) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      bus.row_valid <= beat;
      bus.row_load  <= beat & (beat_k == '0);
      if (beat) begin
        bus.row_x            <= mem[rd_bank][xidx];
        bus.row_z            <= mem[rd_bank][zidx];
        bus.row_sum_diff_sel <= beat_diff;
      end
    end
  end
endmodule

// File: tb/tb_x2z_row_feeder.sv
// tb_x2z_row_feeder: directed scenarios plus a random phase, checked against
// a block-level model (completed blocks expand to their expected beat list;
// in_ready/busy derive from counts of blocks written vs. blocks emitted).
module tb_x2z_row_feeder;
  localparam int DW = 8;
  localparam int N  = 8;

  typedef struct packed {
    logic [DW-1:0] x, z;
    logic          sel, load, last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  x2z_row_feeder_if #(.DATA_WIDTH(DW)) bus();
  x2z_row_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / monitor (negedge) ----------------
  beat_t         expq[$];
  logic [DW-1:0] cur[$];
  beat_t         mb;
  int            completed = 0, emitted = 0;
  int            cyc = 0, hs_cyc = 0, start_cyc = 0;
  bit            pend_rst = 1'b0, hs_pend = 1'b0;
  logic [DW-1:0] hs_data;
  logic          exp_rdy;

  always @(negedge clk) begin
    cyc++;
    if (cyc >= 2) begin
      if (pend_rst) begin
        expq.delete();
        cur.delete();
        completed = 0;
        emitted   = 0;
        chk("rst_valid", 32'(bus.row_valid), 0);
        chk("rst_load",  32'(bus.row_load), 0);
        chk("rst_sel",   32'(bus.row_sum_diff_sel), 0);
        chk("rst_x",     32'(bus.row_x), 0);
        chk("rst_z",     32'(bus.row_z), 0);
        chk("rst_busy",  32'(busy), 0);
      end else begin
        if (hs_pend) begin
          cur.push_back(hs_data);
          if (cur.size() == N) begin
            for (int k = 0; k < N/2; k++)
              expq.push_back('{x:cur[k], z:cur[N-1-k], sel:1'b0, load:(k == 0), last:1'b0});
            for (int k = 0; k < N/2; k++)
              expq.push_back('{x:cur[k], z:cur[N-1-k], sel:1'b1, load:(k == 0), last:(k == N/2-1)});
            cur.delete();
            completed++;
          end
        end
        if (bus.row_valid === 1'b1) begin
          if (expq.size() == 0) begin
            chk("spurious_beat", 1, 0);
          end else begin
            mb = expq.pop_front();
            chk("beat_x",    32'(bus.row_x), 32'(mb.x));
            chk("beat_z",    32'(bus.row_z), 32'(mb.z));
            chk("beat_sel",  32'(bus.row_sum_diff_sel), 32'(mb.sel));
            chk("beat_load", 32'(bus.row_load), 32'(mb.load));
            if (mb.last) emitted++;
            if (mb.load && !mb.sel) start_cyc = cyc;
          end
        end else begin
          chk("idle_load", 32'(bus.row_load), 0);
        end
        chk("busy", 32'(busy), 32'(completed > emitted));
      end
      exp_rdy = rst_n && ((completed - emitted) < 2);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    end
    hs_pend = rst_n && bus.in_valid && bus.in_ready;
    hs_data = bus.in_data;
    if (hs_pend) hs_cyc = cyc;
    pend_rst = !rst_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample; returns the number of cycles it waited for in_ready.
  task automatic push(input logic [DW-1:0] d, output int w);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("push_timeout", 1, 0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for the next run of valid beats; report its length and busy on its last beat.
  task automatic run_len(output int len, output logic lb);
    int t;
    t = 0; len = 0; lb = 1'b1;
    @(negedge clk);
    while (bus.row_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("run_timeout", 1, 0);
    while (bus.row_valid === 1'b1 && len < 100) begin
      len++;
      lb = busy;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy !== 1'b0 || bus.row_valid !== 1'b0) && t < 300);
    if (t >= 300) chk("idle_timeout", 1, 0);
    tick();
  endtask

  int   w, wsum, w17, len, t;
  logic lb;

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.hold = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.in_ready), 1);
    chk("reset_busy",  32'(busy), 0);
    tick();

    // single block
    for (int i = 1; i <= N; i++) push(DW'(i), w);
    run_len(len, lb);
    chk("single_len", 32'(len), 8);
    chk("single_lat", 32'(start_cyc - hs_cyc), 2);
    chk("single_busy_end", 32'(lb), 0);
    wait_idle();

    // back-to-back blocks, no stall on in_ready, one contiguous run
    wsum = 0;
    fork
      begin
        for (int i = 1; i <= 2*N; i++) begin push(DW'(i), w); wsum += w; end
      end
      begin
        run_len(len, lb);
      end
    join
    chk("b2b_ready_stall", 32'(wsum), 0);
    chk("b2b_len", 32'(len), 16);
    wait_idle();

    // back-pressure: hold while streaming 24 samples
    bus.hold = 1'b1;
    wsum = 0; w17 = 0;
    fork
      begin
        for (int i = 1; i <= 3*N; i++) begin
          push(DW'(i), w);
          if (i <= 2*N) wsum += w;
          if (i == 2*N+1) w17 = w;
        end
      end
      begin
        repeat (30) tick();
        bus.hold = 1'b0;
      end
    join
    chk("bp_first16_stall", 32'(wsum), 0);
    chk("bp_sample17_waited", 32'(w17 > 10), 1);
    wait_idle();
    chk("bp_drain", 32'(expq.size()), 0);

    // mid-block stall after the (2,7) sum beat
    fork
      begin
        for (int i = 1; i <= N; i++) push(DW'(i), w);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!(bus.row_valid === 1'b1 && bus.row_x == 2 && bus.row_sum_diff_sel == 1'b0) && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) chk("stall_timeout", 1, 0);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_valid", 32'(bus.row_valid), 0);
          chk("stall_x", 32'(bus.row_x), 2);
          chk("stall_z", 32'(bus.row_z), 7);
          chk("stall_sel", 32'(bus.row_sum_diff_sel), 0);
        end
        bus.hold = 1'b0;
        @(negedge clk);
        chk("resume_valid", 32'(bus.row_valid), 1);
        chk("resume_x", 32'(bus.row_x), 3);
        chk("resume_z", 32'(bus.row_z), 6);
        chk("resume_load", 32'(bus.row_load), 0);
        tick();
      end
    join
    wait_idle();
    chk("stall_drain", 32'(expq.size()), 0);

    // reset mid-operation: block 1 emitting, 5 samples of block 2 written
    for (int i = 1; i <= N+5; i++) push(DW'(i), w);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_valid", 32'(bus.row_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.in_ready), 1);
    tick();
    for (int i = 101; i <= 100+N; i++) push(DW'(i), w);
    run_len(len, lb);
    chk("postrst_len", 32'(len), 8);
    wait_idle();
    chk("postrst_drain", 32'(expq.size()), 0);

    // input bubbles on alternate cycles
    for (int i = 1; i <= N; i++) begin
      push(DW'(i), w);
      if (i != N) tick();
    end
    run_len(len, lb);
    chk("bubble_len", 32'(len), 8);
    chk("bubble_lat", 32'(start_cyc - hs_cyc), 2);
    wait_idle();

    // random traffic with random hold
    repeat (600) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DW'($urandom);
      bus.hold     = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    wait_idle();
    chk("rand_drain", 32'(expq.size()), 0);
    chk("rand_blocks_done", 32'(completed == emitted), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
